xdisp_scan_ctrl: RTL and testbench

Parametrised multiplexed seven-segment display controller and successor to the fixed 4-digit, 8-bit display decoder. It converts a signed-magnitude binary value to BCD with a sequential double-dabble engine instead of a combinational loop, and commits the result atomically. It then scans N common-anode digits with a programmable refresh period. It also adds leading-zero blanking, overflow detection, a busy handshake and text messages, and sits between the calculator datapath/bus and the board display pins.

---
 rtl/xdisp_pkg.sv | 78 +++++++
 rtl/xdisp_dabble.sv | 76 +++++++
 rtl/xdisp_scan_ctrl.sv | 129 ++++++++++++
 tb/tb_xdisp_scan_ctrl.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/xdisp_pkg.sv
// Shared constants for the multiplexed seven-segment display controller:
// active-low segment codes, message encodings, converter states and lookups.
package xdisp_pkg;

  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_MINUS = 8'hBF;
  localparam logic [7:0] SEG_O     = 8'hC0;
  localparam logic [7:0] SEG_R     = 8'hAF;
  localparam logic [7:0] SEG_E     = 8'h86;
  localparam logic [7:0] SEG_P     = 8'h8C;
  localparam logic [7:0] SEG_V     = 8'hC1;
  localparam logic [7:0] SEG_A     = 8'h88;
  localparam logic [7:0] SEG_L     = 8'hC7;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  localparam logic [1:0] MSG_NUM = 2'b00;
  localparam logic [1:0] MSG_OP  = 2'b01;
  localparam logic [1:0] MSG_VAL = 2'b10;
  localparam logic [1:0] MSG_ERR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  function automatic logic [7:0] nibble_to_seg(input logic [3:0] nib);
    logic [7:0] seg;
    seg = SEG_BLANK;
    case (nib)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

  // pos counts from the leftmost digit; text is left-justified
  function automatic logic [7:0] msg_seg(input logic [1:0] m, input int pos);
    logic [7:0] seg;
    seg = SEG_BLANK;
    case (m)
      MSG_OP: begin
        if (pos == 0) seg = SEG_O;
        else if (pos == 1) seg = SEG_P;
      end
      MSG_VAL: begin
        if (pos == 0) seg = SEG_V;
        else if (pos == 1) seg = SEG_A;
        else if (pos == 2) seg = SEG_L;
      end
      MSG_ERR: begin
        if (pos == 0) seg = SEG_E;
        else if (pos == 1 || pos == 2) seg = SEG_R;
      end
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/xdisp_dabble.sv
// Sequential double-dabble converter: BIN_W shift cycles, then a one-cycle
// done pulse while the BCD result is stable for the caller to commit.
module xdisp_dabble
  import xdisp_pkg::*;
#(
  parameter int N_DIGITS = 4,
  parameter int BIN_W    = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [BIN_W-1:0]        bin,
  output logic                    busy,
  output logic                    done,
  output logic [N_DIGITS*4-1:0]   bcd,
  output logic                    ovf
);

  localparam int BCD_W = N_DIGITS * 4;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

  state_t             state, state_nx;
  logic [BIN_W-1:0]   sr;
  logic [BCD_W-1:0]   acc, acc_adj;
  logic [CNT_W-1:0]   cnt;
  logic               carry;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:   if (start) state_nx = ST_SHIFT;
      ST_SHIFT:  if (cnt == LAST_CNT) state_nx = ST_COMMIT;
      ST_COMMIT: state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    acc_adj = acc;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (acc[i*4 +: 4] > 4'd4) acc_adj[i*4 +: 4] = acc[i*4 +: 4] + 4'd3;
    end
  end

  // A one shifted out of the top nibble means the value cannot fit at all
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr    <= '0;
      acc   <= '0;
      cnt   <= '0;
      carry <= 1'b0;
    end else if (state == ST_IDLE && start) begin
      sr    <= bin;
      acc   <= '0;
      cnt   <= '0;
      carry <= 1'b0;
    end else if (state == ST_SHIFT) begin
      acc   <= {acc_adj[BCD_W-2:0], sr[BIN_W-1]};
      sr    <= {sr[BIN_W-2:0], 1'b0};
      carry <= carry | acc_adj[BCD_W-1];
      cnt   <= cnt + CNT_W'(1);
    end
  end

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_COMMIT);
  assign bcd  = acc;
  assign ovf  = carry | (acc[BCD_W-1 -: 4] != 4'd0);

endmodule

// File: rtl/xdisp_scan_ctrl.sv
// Multiplexed seven-segment controller: atomic commit of converted values,
// digit scanning, leading-zero blanking and text message overlay.
module xdisp_scan_ctrl
  import xdisp_pkg::*;
#(
  parameter int N_DIGITS   = 4,
  parameter int BIN_W      = 8,
  parameter int SCAN_DIV_W = 18,
  parameter int BLANK_LZ   = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wr_en,
  input  logic                          display_sel,
  input  logic [BIN_W-1:0]              bin,
  input  logic                          sgn,
  input  logic [$clog2(N_DIGITS)-1:0]   dot,
  input  logic [1:0]                    msg,
  output logic                          busy,
  output logic [N_DIGITS-1:0]           disp_select,
  output logic [7:0]                    disp_value
);

  localparam int IDX_W = $clog2(N_DIGITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_DIGITS - 1);

  logic                    accept, conv_done, conv_ovf;
  logic [N_DIGITS*4-1:0]   conv_bcd;
  logic                    cap_sgn;
  logic [IDX_W-1:0]        cap_dot;
  logic [N_DIGITS*4-1:0]   shown_bcd;
  logic                    shown_sgn, shown_ovf;
  logic [IDX_W-1:0]        shown_dot;
  logic [SCAN_DIV_W-1:0]   presc;
  logic [IDX_W-1:0]        scan_idx;
  logic [N_DIGITS-1:0]     lz;
  logic                    upper_zero;
  logic [1:0]              eff_msg;
  logic [3:0]              cur_nib;
  logic [7:0]              seg_nx;

  assign accept = wr_en & display_sel & ~busy;

  xdisp_dabble #(
    .N_DIGITS (N_DIGITS),
    .BIN_W    (BIN_W)
  ) u_dabble (
    .clk   (clk),
    .rst_n (rst_n),
    .start (accept),
    .bin   (bin),
    .busy  (busy),
    .done  (conv_done),
    .bcd   (conv_bcd),
    .ovf   (conv_ovf)
  );

  // Display registers only change on commit, so no half-converted digits show
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_sgn   <= 1'b0;
      cap_dot   <= '0;
      shown_bcd <= '0;
      shown_sgn <= 1'b0;
      shown_dot <= '0;
      shown_ovf <= 1'b0;
    end else begin
      if (accept) begin
        cap_sgn <= sgn;
        cap_dot <= dot;
      end
      if (conv_done) begin
        shown_bcd <= conv_bcd;
        shown_sgn <= cap_sgn;
        shown_dot <= cap_dot;
        shown_ovf <= conv_ovf;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc    <= '0;
      scan_idx <= '0;
    end else begin
      presc <= presc + SCAN_DIV_W'(1);
      if (&presc) scan_idx <= (scan_idx == LAST_IDX) ? '0 : scan_idx + IDX_W'(1);
    end
  end

  // lz[i]: magnitude nibble i and every higher magnitude nibble are zero
  always_comb begin
    upper_zero = 1'b1;
    lz         = '0;
    for (int i = N_DIGITS - 2; i >= 0; i--) begin
      upper_zero = upper_zero & (shown_bcd[i*4 +: 4] == 4'd0);
      lz[i]      = upper_zero;
    end
  end

  always_comb begin
    eff_msg = (msg == MSG_NUM && shown_ovf) ? MSG_ERR : msg;
    cur_nib = shown_bcd[scan_idx*4 +: 4];
    seg_nx  = SEG_BLANK;
    if (eff_msg != MSG_NUM) begin
      seg_nx = msg_seg(eff_msg, int'(LAST_IDX - scan_idx));
    end else if (scan_idx == LAST_IDX) begin
      seg_nx = shown_sgn ? SEG_MINUS : SEG_BLANK;
    end else begin
      if (BLANK_LZ != 0 && scan_idx != '0 && lz[scan_idx] && scan_idx > shown_dot)
        seg_nx = SEG_BLANK;
      else
        seg_nx = nibble_to_seg(cur_nib);
      if (shown_dot != '0 && scan_idx == shown_dot)
        seg_nx[7] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_select <= '1;
      disp_value  <= SEG_BLANK;
    end else begin
      disp_select <= ~(N_DIGITS'(1) << scan_idx);
      disp_value  <= seg_nx;
    end
  end

endmodule

// File: tb/tb_xdisp_scan_ctrl.sv
// Directed bench for xdisp_scan_ctrl with a fast scan (4 cycles per digit)
// and a 10-bit magnitude so the overflow case fits the same instance.
module tb_xdisp_scan_ctrl;

  localparam int N_DIGITS = 4;
  localparam int BIN_W    = 10;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b1;
  logic                 wr_en = 1'b0;
  logic                 display_sel = 1'b0;
  logic [BIN_W-1:0]     bin = '0;
  logic                 sgn = 1'b0;
  logic [1:0]           dot = '0;
  logic [1:0]           msg = '0;
  logic                 busy;
  logic [N_DIGITS-1:0]  disp_select;
  logic [7:0]           disp_value;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  xdisp_scan_ctrl #(
    .N_DIGITS   (N_DIGITS),
    .BIN_W      (BIN_W),
    .SCAN_DIV_W (2),
    .BLANK_LZ   (1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en       (wr_en),
    .display_sel (display_sel),
    .bin         (bin),
    .sgn         (sgn),
    .dot         (dot),
    .msg         (msg),
    .busy        (busy),
    .disp_select (disp_select),
    .disp_value  (disp_value)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [BIN_W-1:0] b, input logic s, input logic [1:0] d);
    @(negedge clk);
    bin = b; sgn = s; dot = d;
    wr_en = 1'b1; display_sel = 1'b1;
    @(negedge clk);
    wr_en = 1'b0; display_sel = 1'b0;
  endtask

  task automatic checkBusyLen(input string tag);
    int n;
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
    end
    checkOutput(tag, n, BIN_W + 1);
  endtask

  task automatic waitIdle(input string tag);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 40) begin
      n++;
      @(negedge clk);
    end
    checkOutput(tag, busy, 1'b0);
  endtask

  task automatic checkDigit(input string tag, input int k, input logic [7:0] exp);
    logic [3:0] sel;
    int n;
    sel = ~(4'b0001 << k);
    n = 0;
    while (disp_select !== sel && n < 64) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_sel"}, disp_select, sel);
    checkOutput(tag, disp_value, exp);
  endtask

  task automatic checkNextSelect(input string tag, input logic [3:0] exp);
    logic [3:0] prev;
    int n;
    prev = disp_select;
    n = 0;
    while (disp_select === prev && n < 16) begin
      @(negedge clk);
      n++;
    end
    checkOutput(tag, disp_select, exp);
  endtask

  initial begin
    // reset state
    #2 rst_n = 1'b0;
    #20;
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_sel", disp_select, 4'b1111);
    checkOutput("rst_val", disp_value, 8'hFF);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: idle scan of committed zero
    checkDigit("t1_d0", 0, 8'hC0);
    checkNextSelect("t1_next1", 4'b1101);
    checkOutput("t1_d1", disp_value, 8'hFF);
    checkNextSelect("t1_next2", 4'b1011);
    checkOutput("t1_d2", disp_value, 8'hFF);
    checkNextSelect("t1_next3", 4'b0111);
    checkOutput("t1_d3", disp_value, 8'hFF);
    checkNextSelect("t1_wrap", 4'b1110);

    // 2: -255
    applyStimulus(10'd255, 1'b1, 2'd0);
    checkBusyLen("t2_busylen");
    checkDigit("t2_d0", 0, 8'h92);
    checkDigit("t2_d1", 1, 8'h92);
    checkDigit("t2_d2", 2, 8'hA4);
    checkDigit("t2_d3", 3, 8'hBF);

    // 3: 7 with point on digit 2 keeps digits 1..2 unblanked
    applyStimulus(10'd7, 1'b0, 2'd2);
    checkBusyLen("t3_busylen");
    checkDigit("t3_d0", 0, 8'hF8);
    checkDigit("t3_d1", 1, 8'hC0);
    checkDigit("t3_d2", 2, 8'h40);
    checkDigit("t3_d3", 3, 8'hFF);

    // 4: write while busy is dropped
    applyStimulus(10'd42, 1'b0, 2'd0);
    checkOutput("t4_busy", busy, 1'b1);
    applyStimulus(10'd99, 1'b1, 2'd1);
    waitIdle("t4_idle");
    checkDigit("t4_d0", 0, 8'hA4);
    checkDigit("t4_d1", 1, 8'h99);
    checkDigit("t4_d2", 2, 8'hFF);
    checkDigit("t4_d3", 3, 8'hFF);

    // 5: 1000 overflows three magnitude digits
    applyStimulus(10'd1000, 1'b0, 2'd0);
    checkBusyLen("t5_busylen");
    checkDigit("t5_d3", 3, 8'h86);
    checkDigit("t5_d2", 2, 8'hAF);
    checkDigit("t5_d1", 1, 8'hAF);
    checkDigit("t5_d0", 0, 8'hFF);

    // 6: live messages
    msg = 2'b10;
    checkDigit("t6_val_d3", 3, 8'hC1);
    checkDigit("t6_val_d2", 2, 8'h88);
    checkDigit("t6_val_d1", 1, 8'hC7);
    checkDigit("t6_val_d0", 0, 8'hFF);
    msg = 2'b01;
    checkDigit("t6_op_d3", 3, 8'hC0);
    checkDigit("t6_op_d2", 2, 8'h8C);
    checkDigit("t6_op_d1", 1, 8'hFF);
    msg = 2'b00;

    // negative zero and a point on digit 1
    applyStimulus(10'd0, 1'b1, 2'd0);
    waitIdle("t7_idle");
    checkDigit("t7_d3", 3, 8'hBF);
    checkDigit("t7_d1", 1, 8'hFF);
    checkDigit("t7_d0", 0, 8'hC0);
    applyStimulus(10'd5, 1'b0, 2'd1);
    waitIdle("t8_idle");
    checkDigit("t8_d0", 0, 8'h92);
    checkDigit("t8_d1", 1, 8'h40);
    checkDigit("t8_d2", 2, 8'hFF);

    // reset in the middle of a conversion
    applyStimulus(10'd500, 1'b1, 2'd0);
    @(negedge clk);
    @(negedge clk);
    checkOutput("t9_busy_pre", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    checkOutput("t9_busy", busy, 1'b0);
    checkOutput("t9_sel", disp_select, 4'b1111);
    checkOutput("t9_val", disp_value, 8'hFF);
    @(negedge clk);
    rst_n = 1'b1;
    checkDigit("t9_d0", 0, 8'hC0);
    checkDigit("t9_d3", 3, 8'hFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
